uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised UART receiver with configurable word length, parity and stop bits, line-error detection and a small first-word-fall-through output FIFO. It generalises the MIDI RX front end: it decodes 31250-baud MIDI by default but also serves debug/config serial links in the same design. It sits between the asynchronous serial input pin and downstream consumers such as the MIDI message parser, which drain words through a valid/ready handshake.

## Interface
- `CLK_HZ`, 10_000_000, system clock frequency
- `BAUD`, 31250, line rate; bit period `CYC = CLK_HZ / BAUD` (integer division, must be ≥ 8)
- `DATA_BITS`, 8, payload bits per frame, legal range 5..9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 4, output FIFO entries, power of two, ≥ 2
- `clk_i` in 1: system clock, single clock domain
- `nrst_i` in 1: reset, asynchronous, active-low
- `rxData_i` in 1: asynchronous serial line, idle high
- `data_o` out DATA_BITS: head-of-FIFO payload, LSB = first received bit
- `valid_o` out 1: FIFO non-empty
- `ready_i` in 1: consumer accepts head word when `valid_o & ready_i`
- `frameErr_o` out 1: head word had a low stop bit
- `parityErr_o` out 1: head word failed parity (always 0 when `PARITY = 0`)
- `overrun_o` out 1: sticky; a frame was dropped because the FIFO was full
- `clearErr_i` in 1: clears `overrun_o`
- `fifoLevel_o` out `$clog2(FIFO_DEPTH)+1`: occupied entries, 0..FIFO_DEPTH
- `busy_o` out 1: high whenever the FSM is not in IDLE

## Operation
- Input passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the second flop (`rxS`).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `armed` is set when `rxS = 1`. When `armed` and `rxS = 0`, go to START and clear the bit counter. A line held low after a frame never retriggers until it has been seen high.
- START: count `CYC/2` cycles, then sample.
  - Sample 0: go to DATA.
  - Sample 1 (glitch or false start): return to IDLE with nothing pushed.
  - In both cases clear the bit counter.
- DATA: sample every `CYC` cycles at counter = CYC-1. Shift LSB-first into the data register. After DATA_BITS samples, go to PARITY if `PARITY != 0`, otherwise go to STOP.
- PARITY: one sample. `parityErr = (XOR(data) ^ sample) != (PARITY == 1)`, i.e. odd parity requires an odd total number of ones.
- STOP: STOP_BITS samples. `frameErr` is set if any stop sample is 0.
  - On the last stop sample, push {parityErr, frameErr, data} and go straight to IDLE, at mid-bit, to allow back-to-back frames.
  - `armed` is cleared on this transition.
- FIFO:
  - Push and pop on the same cycle are both allowed at any level, including full.
  - Push while full with no pop: the frame is dropped and `overrun_o` is set.
  - `clearErr_i` clears `overrun_o`. If it coincides with an overrun event, set wins.
- `data_o`, `frameErr_o` and `parityErr_o` are forced to 0 while `valid_o = 0`.
- Reset, including mid-frame: state IDLE, FIFO empty, `armed = 0`, all outputs 0. Any partial frame is discarded.

## Timing
- Let E0 be the clock edge that first captures `rxData_i = 0`. `rxS` is low after E1; START is entered at E2.
- The start sample is taken at E2 + CYC/2. Each subsequent sample follows `CYC` cycles after the previous one.
- Let N = DATA_BITS + (PARITY ? 1 : 0) + STOP_BITS. The push occurs at E2 + CYC/2 + N·CYC. `valid_o` and `fifoLevel_o` update on that edge.
- Default 8N1 at CYC = 320: push at E2 + 3040.
- A pop takes effect at the edge where `valid_o & ready_i`. The next head word (or `valid_o = 0`) is visible after that edge.
- `busy_o` follows the registered FSM state: high from E2 until the push edge.

## Test plan
- **8N1 defaults.** Send 0x90, 0x3C, 0x7F back-to-back with `ready_i = 1`.
  - Required: three words in order, each with `valid_o` high for exactly one cycle.
  - Required: both error flags 0; push 3042 cycles after each start edge.
- **PARITY = 2, DATA_BITS = 7.** Send 0x41 with correct parity bit 0, then 0x41 with parity bit 1.
  - Required: first word has `parityErr_o = 0`; second word has `parityErr_o = 1`, with `data_o = 0x41` for both.
- **Framing error and break.** Send 0x55 with a low stop bit, then hold the line low for 3 frame times, then send 0xAA.
  - Required: exactly two words, 0x55 with `frameErr_o = 1` and then 0xAA clean.
- **False start.** Pulse the line low for CYC/4 cycles.
  - Required: return to IDLE, nothing pushed, `busy_o` high for about CYC/2 cycles.
- **Overrun with FIFO_DEPTH = 4 and `ready_i = 0`.** Send 5 frames.
  - Required: `fifoLevel_o = 4` and `overrun_o = 1`; frames 1–4 are retained.
  - Required: pulse `clearErr_i` clears `overrun_o`; popping with `ready_i` yields frames 1–4 in order.
- **Reset mid-frame.** Assert `nrst_i` low during DATA bit 3 with 2 words queued.
  - Required: all outputs 0 and `fifoLevel_o = 0`.
  - Required: a following clean frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (N data, optional parity, 1/2 stop) feeding a first-word-fall-through FIFO.
// Word visible on the mid-stop-bit push edge; ready_i pops, and a full FIFO with no pop drops the frame.

module uart_rx_fifo_buf #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    nrst_i,
   input  logic                    wrVld,
   input  logic [WIDTH-1:0]        wrDat,
   output logic                    wrRdy,
   output logic                    rdVld,
   output logic [WIDTH-1:0]        rdDat,
   input  logic                    rdRdy,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      count;
   logic             wrEn;
   logic             rdEn;

   assign rdVld = (count != '0);
   // A pop frees the slot in the same cycle, so a full FIFO can still accept.
   assign wrRdy = (count != FULL) || rdRdy;
   assign wrEn  = wrVld && wrRdy;
   assign rdEn  = rdVld && rdRdy;
   assign rdDat = mem[rdPtr];
   assign level = count;

   always_ff @(posedge clk_i) begin
      if (wrEn) mem[wrPtr] <= wrDat;
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (wrEn) wrPtr <= wrPtr + 1'b1;
         if (rdEn) rdPtr <= rdPtr + 1'b1;
         case ({wrEn, rdEn})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module uart_rx_fifo #(
   parameter int CLK_HZ     = 10_000_000,
   parameter int BAUD       = 31250,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          nrst_i,
   input  logic                          rxData_i,
   output logic [DATA_BITS-1:0]          data_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          frameErr_o,
   output logic                          parityErr_o,
   output logic                          overrun_o,
   input  logic                          clearErr_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevel_o,
   output logic                          busy_o
);
   localparam int CYC  = CLK_HZ / BAUD;
   localparam int HALF = CYC / 2;
   localparam int CW   = $clog2(CYC);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

   typedef struct packed {
      logic                 parityErr;
      logic                 frameErr;
      logic [DATA_BITS-1:0] data;
   } entry_t;

   state_t               state;
   state_t               stateNext;
   logic                 rxMeta;
   logic                 rxS;
   logic                 armed;
   logic [CW-1:0]        cnt;
   logic [3:0]           bitCnt;
   logic [DATA_BITS-1:0] dataReg;
   logic                 parErrReg;
   logic                 frameErrReg;
   logic                 bitTick;
   logic                 cntClr;
   logic                 bitClr;
   logic                 shiftEn;
   logic                 parEn;
   logic                 stopEn;
   logic                 push;
   logic                 pushRdy;
   logic                 headVld;
   entry_t               pushEntry;
   entry_t               headEntry;

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= rxData_i;
         rxS    <= rxMeta;
      end
   end

   assign bitTick = (cnt == CW'(CYC-1));

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) state <= ST_IDLE;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      cntClr    = 1'b0;
      bitClr    = 1'b0;
      shiftEn   = 1'b0;
      parEn     = 1'b0;
      stopEn    = 1'b0;
      push      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (armed && !rxS) begin
               stateNext = ST_START;
               cntClr    = 1'b1;
               bitClr    = 1'b1;
            end
         end
         ST_START: begin
            if (cnt == CW'(HALF-1)) begin
               cntClr    = 1'b1;
               bitClr    = 1'b1;
               stateNext = rxS ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (bitTick) begin
               shiftEn = 1'b1;
               cntClr  = 1'b1;
               if (bitCnt == 4'(DATA_BITS-1)) begin
                  bitClr    = 1'b1;
                  stateNext = (PARITY != 0) ? ST_PAR : ST_STOP;
               end
            end
         end
         ST_PAR: begin
            if (bitTick) begin
               parEn     = 1'b1;
               cntClr    = 1'b1;
               stateNext = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bitTick) begin
               stopEn = 1'b1;
               cntClr = 1'b1;
               if (bitCnt == 4'(STOP_BITS-1)) begin
                  push      = 1'b1;
                  bitClr    = 1'b1;
                  stateNext = ST_IDLE;
               end
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         cnt         <= '0;
         bitCnt      <= '0;
         dataReg     <= '0;
         parErrReg   <= 1'b0;
         frameErrReg <= 1'b0;
         armed       <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         cnt <= cntClr ? '0 : cnt + 1'b1;
         if (bitClr)                bitCnt <= '0;
         else if (shiftEn || stopEn) bitCnt <= bitCnt + 1'b1;
         if (shiftEn) dataReg <= {rxS, dataReg[DATA_BITS-1:1]};
         if (state == ST_START) begin
            parErrReg   <= 1'b0;
            frameErrReg <= 1'b0;
         end
         if (parEn) parErrReg <= ((^dataReg) ^ rxS) != (PARITY == 1);
         if (stopEn && !rxS) frameErrReg <= 1'b1;
         // The line must be seen idle again before another start is accepted.
         if (push)                          armed <= 1'b0;
         else if (state == ST_IDLE && rxS)  armed <= 1'b1;
         if (push && !pushRdy) overrun_o <= 1'b1;
         else if (clearErr_i)  overrun_o <= 1'b0;
      end
   end

   assign pushEntry.parityErr = parErrReg;
   assign pushEntry.frameErr  = frameErrReg | ~rxS;
   assign pushEntry.data      = dataReg;

   uart_rx_fifo_buf #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .nrst_i (nrst_i),
      .wrVld  (push),
      .wrDat  (pushEntry),
      .wrRdy  (pushRdy),
      .rdVld  (headVld),
      .rdDat  (headEntry),
      .rdRdy  (ready_i),
      .level  (fifoLevel_o)
   );

   assign valid_o     = headVld;
   assign data_o      = headVld ? headEntry.data : '0;
   assign frameErr_o  = headVld & headEntry.frameErr;
   assign parityErr_o = headVld & headEntry.parityErr;
   assign busy_o      = (state != ST_IDLE);
endmodule
